// File: rtl/memory_stage_if.sv
// Memory-stage bus: execution-stage operands in, write-back payload and stall out.
//   master : upstream side (drives ex-stage fields, observes write-back fields and stall)
//   slave  : memory_stage (consumes ex-stage fields, drives write-back fields and stall)
interface memory_stage_if;

   logic [7:0] ans_ex;          // execution result
   logic [7:0] data_out;        // store data
   logic [7:0] B_Bypass;        // memory address
   logic       mem_en_ex;       // op accesses memory
   logic       mem_rw_ex;       // 1 = store, 0 = load
   logic       mem_mux_sel_ex;  // 1 = write back load data
   logic [4:0] RW_ex;           // destination register

   logic [7:0] ans_mem;         // registered write-back value
   logic [4:0] RW_mem;          // registered destination
   logic       wb_en_mem;       // registered write enable
   logic       stall_mem;       // combinational hold request

   modport master (
      output ans_ex, data_out, B_Bypass, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, RW_ex,
      input  ans_mem, RW_mem, wb_en_mem, stall_mem
   );

   modport slave (
      input  ans_ex, data_out, B_Bypass, mem_en_ex, mem_rw_ex, mem_mux_sel_ex, RW_ex,
      output ans_mem, RW_mem, wb_en_mem, stall_mem
   );

endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: owns the byte-wide data memory, performs loads/stores with
// WAIT_CYC wait states and registers the write-back payload.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : memory_stage_if.slave (ex-stage inputs, write-back outputs, stall_mem)
module memory_stage #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned WAIT_CYC = 0
) (
   input logic           clk,
   input logic           reset,
   memory_stage_if.slave bus
);

   localparam int unsigned DEPTH    = 1 << ADDR_W;
   localparam logic [2:0]  WAIT_LIM = 3'(WAIT_CYC);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t            state_q, state_d;
   logic [2:0]        wcnt_q, wcnt_d;
   logic [7:0]        ans_q, ans_d;
   logic [4:0]        rw_q, rw_d;
   logic              wb_q, wb_d;
   logic              mem_we;
   logic              stall_c;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        rd_data;
   logic [7:0]        mem [DEPTH];

   // Address wraps modulo depth: only the low ADDR_W bits select a byte.
   assign addr    = bus.B_Bypass[ADDR_W-1:0];
   assign rd_data = mem[addr];

   generate
      if (ADDR_W < 8) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^bus.B_Bypass[7:ADDR_W];
      end
   endgenerate

   // Hold upstream until the access reaches its final wait count.
   assign stall_c       = reset & bus.mem_en_ex & (wcnt_q != WAIT_LIM);
   assign bus.stall_mem = stall_c;

   // State, wait counter and write-back registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         wcnt_q  <= 3'd0;
         ans_q   <= 8'd0;
         rw_q    <= 5'd0;
         wb_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         ans_q   <= ans_d;
         rw_q    <= rw_d;
         wb_q    <= wb_d;
      end
   end

   // Next-state and write-back payload selection.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      ans_d   = ans_q;
      rw_d    = rw_q;
      wb_d    = wb_q;
      mem_we  = 1'b0;

      if (!bus.mem_en_ex) begin
         // Plain ALU op; also recovers from an access abandoned mid-wait.
         state_d = ST_IDLE;
         wcnt_d  = 3'd0;
         ans_d   = bus.ans_ex;
         rw_d    = bus.RW_ex;
         wb_d    = (bus.RW_ex != 5'd0);
      end else if (wcnt_q != WAIT_LIM) begin
         // Wait state: count up and send a bubble downstream, ans_mem holds.
         state_d = ST_WAIT;
         wcnt_d  = (state_q == ST_IDLE) ? 3'd1 : wcnt_q + 3'd1;
         rw_d    = 5'd0;
         wb_d    = 1'b0;
      end else begin
         // Completing edge of the access.
         state_d = ST_IDLE;
         wcnt_d  = 3'd0;
         rw_d    = bus.RW_ex;
         if (bus.mem_rw_ex) begin
            mem_we = reset;
            ans_d  = bus.ans_ex;
            wb_d   = 1'b0;
         end else begin
            ans_d  = bus.mem_mux_sel_ex ? rd_data : bus.ans_ex;
            wb_d   = (bus.RW_ex != 5'd0);
         end
      end
   end

   // Data memory: contents survive reset, written only on a completing store edge.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[addr] <= bus.data_out;
      end
   end

   assign bus.ans_mem   = ans_q;
   assign bus.RW_mem    = rw_q;
   assign bus.wb_en_mem = wb_q;

endmodule
